// File: rtl/gates_pkg.sv
// Shared definitions for the cell-built skid register: state encoding and the
// names of the library cells it is assembled from.
package gates_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b10,
        SKID_TWO   = 2'b11
    } skid_state_t;

    localparam string CELL_DFF = "DFFRX1";
    localparam string CELL_MUX = "MX2X1";
    localparam string CELL_AND = "AND2X1";
    localparam string CELL_INV = "INVX1";

    // Flop count for a skid register of the given width: main + skid + two state bits.
    function automatic int unsigned skid_dff_count(input int unsigned width);
        return 2 * width + 2;
    endfunction

endpackage

// File: rtl/AND2X1.sv
// Library model: 2-input AND.
module AND2X1 (
    input  logic A,
    input  logic B,
    output logic Y
);
    assign Y = A & B;
endmodule

// File: rtl/DFFRX1.sv
// Library model: rising-edge D flop with asynchronous active-low clear.
module DFFRX1 (
    input  logic D,
    input  logic CK,
    input  logic RN,
    output logic Q
);
    logic r_q;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) r_q <= 1'b0;
        else     r_q <= D;
    end

    assign Q = r_q;
endmodule

// File: rtl/INVX1.sv
// Library model: inverter.
module INVX1 (
    input  logic A,
    output logic Y
);
    assign Y = ~A;
endmodule

// File: rtl/MX2X1.sv
// Library model: 2:1 mux, Y = S ? B : A.
module MX2X1 (
    input  logic A,
    input  logic B,
    input  logic S,
    output logic Y
);
    assign Y = S ? B : A;
endmodule

// File: rtl/dffr_bank.sv
// WIDTH clearable flops, each with a feedback mux so the bank only loads when
// i_en is high; the clear is the shared active-low RN produced by the parent.
module dffr_bank #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rn,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    import gates_pkg::*;

    logic [WIDTH-1:0] w_d;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            MX2X1  u_hold (.A(o_q[gi]), .B(i_d[gi]), .S(i_en), .Y(w_d[gi]));
            DFFRX1 u_ff   (.D(w_d[gi]), .CK(i_clk), .RN(i_rn), .Q(o_q[gi]));
        end
    endgenerate
endmodule

// File: rtl/skid_reg_cells.sv
// Two-entry valid/ready skid register assembled from library cells only.
// State is {full0, full1}: 00 empty, 10 main valid, 11 main and skid valid.
module skid_reg_cells #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_in_ready,
    output logic             o_out_valid,
    output logic [WIDTH-1:0] o_out_data,
    input  logic             i_out_ready
);
    import gates_pkg::*;

    logic             w_rn;
    logic             w_f0, w_f1, w_nf1;
    logic             w_f0_d, w_f1_d;
    logic             w_in_fire, w_out_fire, w_n_in_fire, w_n_out_fire;
    logic             w_drain, w_drain_one, w_hold0;
    logic             w_fill, w_skid_en;
    logic             w_acc_ok, w_main_ld_in, w_main_en;
    logic [WIDTH-1:0] w_main, w_skid, w_main_d;

    INVX1  u_rn      (.A(i_rst), .Y(w_rn));

    // in_ready comes only from the full1 flop and reset, never from out_ready.
    INVX1  u_nf1     (.A(w_f1), .Y(w_nf1));
    AND2X1 u_rdy     (.A(w_nf1), .B(w_rn), .Y(o_in_ready));

    AND2X1 u_in_fire (.A(i_in_valid), .B(o_in_ready), .Y(w_in_fire));
    AND2X1 u_out_fire(.A(w_f0), .B(i_out_ready), .Y(w_out_fire));
    INVX1  u_n_in    (.A(w_in_fire), .Y(w_n_in_fire));
    INVX1  u_n_out   (.A(w_out_fire), .Y(w_n_out_fire));

    // full0 drops only when a lone beat leaves without a replacement.
    AND2X1 u_drain   (.A(w_n_in_fire), .B(w_out_fire), .Y(w_drain));
    AND2X1 u_drain1  (.A(w_drain), .B(w_nf1), .Y(w_drain_one));
    INVX1  u_hold0   (.A(w_drain_one), .Y(w_hold0));
    MX2X1  u_f0_d    (.A(w_in_fire), .B(w_hold0), .S(w_f0), .Y(w_f0_d));

    // full1 sets when a second beat arrives under stall, clears when the head leaves.
    AND2X1 u_fill    (.A(w_in_fire), .B(w_f0), .Y(w_fill));
    AND2X1 u_skid_en (.A(w_fill), .B(w_n_out_fire), .Y(w_skid_en));
    MX2X1  u_f1_d    (.A(w_skid_en), .B(w_n_out_fire), .S(w_f1), .Y(w_f1_d));

    // main loads from in_data when empty or refilling, from skid when draining TWO.
    MX2X1  u_acc_ok  (.A(1'b1), .B(w_out_fire), .S(w_f0), .Y(w_acc_ok));
    AND2X1 u_main_ld (.A(w_in_fire), .B(w_acc_ok), .Y(w_main_ld_in));
    MX2X1  u_main_en (.A(w_main_ld_in), .B(w_out_fire), .S(w_f1), .Y(w_main_en));

    dffr_bank #(.WIDTH(1)) u_full0 (
        .i_clk(i_clk), .i_rn(w_rn), .i_en(1'b1), .i_d(w_f0_d), .o_q(w_f0)
    );
    dffr_bank #(.WIDTH(1)) u_full1 (
        .i_clk(i_clk), .i_rn(w_rn), .i_en(1'b1), .i_d(w_f1_d), .o_q(w_f1)
    );
    dffr_bank #(.WIDTH(WIDTH)) u_main (
        .i_clk(i_clk), .i_rn(w_rn), .i_en(w_main_en), .i_d(w_main_d), .o_q(w_main)
    );
    dffr_bank #(.WIDTH(WIDTH)) u_skid (
        .i_clk(i_clk), .i_rn(w_rn), .i_en(w_skid_en), .i_d(i_in_data), .o_q(w_skid)
    );

    assign o_out_valid = w_f0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_row
            MX2X1  u_main_mux (.A(i_in_data[gi]), .B(w_skid[gi]), .S(w_f1), .Y(w_main_d[gi]));
            AND2X1 u_out_gate (.A(w_main[gi]), .B(w_f0), .Y(o_out_data[gi]));
        end
    endgenerate
endmodule

// File: tb/tb_skid_reg_cells.sv
// Directed and randomised checks of the cell-built skid register at WIDTH=8.
module tb_skid_reg_cells;
    import gates_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    skid_reg_cells #(.WIDTH(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_in_valid (in_valid),
        .i_in_data  (in_data),
        .o_in_ready (in_ready),
        .o_out_valid(out_valid),
        .o_out_data (out_data),
        .i_out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input skid_state_t exp);
        skid_state_t obs;
        obs = skid_state_t'({out_valid, ~in_ready});
        check(tag, {6'b0, obs}, {6'b0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q[$];
    logic       rdy_before, do_in, do_out, stall;
    logic [7:0] prev_data;

    initial begin
        $display("cells: %s x%0d, %s, %s, %s", CELL_DFF, skid_dff_count(8), CELL_MUX, CELL_AND, CELL_INV);

        // Power-on reset
        #2;
        check("rst_valid", {7'b0, out_valid}, 8'h00);
        check("rst_data", out_data, 8'h00);
        check("rst_ready", {7'b0, in_ready}, 8'h00);
        step();
        rst = 1'b0;
        step();
        check("rel_ready", {7'b0, in_ready}, 8'h01);
        check_state("rel_state", SKID_EMPTY);

        // Streaming
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h11; step();
        check("strm_1", out_data, 8'h11); check("strm_1v", {7'b0, out_valid}, 8'h01);
        $display("stream beat 0x11 -> %h", out_data);
        in_data = 8'h22; step();
        check("strm_2", out_data, 8'h22); check("strm_2v", {7'b0, out_valid}, 8'h01);
        $display("stream beat 0x22 -> %h", out_data);
        in_data = 8'h33; step();
        check("strm_3", out_data, 8'h33); check("strm_3v", {7'b0, out_valid}, 8'h01);
        $display("stream beat 0x33 -> %h", out_data);
        in_valid = 1'b0; step();
        check_state("strm_drain", SKID_EMPTY);
        check("strm_idle", out_data, 8'h00);

        // Backpressure
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hA5; step();
        check_state("bp_one", SKID_ONE);
        check("bp_head", out_data, 8'hA5);
        in_data = 8'h5A; step();
        check_state("bp_two", SKID_TWO);
        check("bp_ready0", {7'b0, in_ready}, 8'h00);
        check("bp_head2", out_data, 8'hA5);
        in_data = 8'hFF; step();
        check_state("bp_reject", SKID_TWO);
        check("bp_hold", out_data, 8'hA5);
        $display("backpressure: holding %h, in_ready=%b", out_data, in_ready);
        out_ready = 1'b1; #1;
        check("bp_out_a5", out_data, 8'hA5);
        step();
        check("bp_out_5a", out_data, 8'h5A);
        check("bp_ready1", {7'b0, in_ready}, 8'h01);
        step();
        check("bp_out_ff", out_data, 8'hFF);
        in_valid = 1'b0; step();
        check_state("bp_empty", SKID_EMPTY);
        $display("backpressure: drained in order a5 5a ff");

        // Simultaneous in_fire and out_fire in ONE
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h01; step();
        check("sim_hold01", out_data, 8'h01);
        out_ready = 1'b1; in_data = 8'h02; step();
        check_state("sim_state", SKID_ONE);
        check("sim_data", out_data, 8'h02);
        $display("simultaneous: out_data=%h", out_data);
        in_valid = 1'b0; step();
        check_state("sim_empty", SKID_EMPTY);

        // Idle gating with unknown input data
        in_valid = 1'b0; in_data = 'x;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_data", out_data, 8'h00);
            check("idle_valid", {7'b0, out_valid}, 8'h00);
        end
        $display("idle: 10 cycles gated");

        // Reset asserted mid-cycle while holding two beats
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hC3; step();
        in_data = 8'h3C; step();
        in_valid = 1'b0;
        check_state("mid_two", SKID_TWO);
        #2 rst = 1'b1;
        #1;
        check("mid_valid", {7'b0, out_valid}, 8'h00);
        check("mid_data", out_data, 8'h00);
        check("mid_ready", {7'b0, in_ready}, 8'h00);
        step();
        rst = 1'b0;
        step();
        check("mid_rel_ready", {7'b0, in_ready}, 8'h01);
        check_state("mid_rel_state", SKID_EMPTY);
        $display("mid-cycle reset: state cleared");

        // Randomised traffic against a queue model
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            rdy_before = in_ready;
            out_ready = ~out_ready;
            #1;
            check("rand_rdy_indep", {7'b0, in_ready}, {7'b0, rdy_before});
            out_ready = ~out_ready;
            #1;
            check("rand_valid", {7'b0, out_valid}, {7'b0, q.size() != 0});
            check("rand_ready", {7'b0, in_ready}, {7'b0, q.size() < 2});
            check("rand_head", out_data, (q.size() != 0) ? q[0] : 8'h00);
            do_in     = in_valid & (q.size() < 2);
            do_out    = out_ready & (q.size() != 0);
            stall     = (q.size() != 0) & ~out_ready;
            prev_data = out_data;
            step();
            if (do_out) void'(q.pop_front());
            if (do_in)  q.push_back(in_data);
            if (stall) check("rand_stall", out_data, prev_data);
        end
        $display("random: 10000 cycles, %0d beats left in model", q.size());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
